sm3_digest_tx: RTL

- Transmit end of the SM3 hasher's byte interface. The hasher core consumes the message one byte per clock; this block returns the 256-bit digest the same way.
- Captures each completed digest from the compression stage and serializes it MSB-first over a valid/ready byte stream to the host-side link.
- Optional ASCII-hex rendering.
- Double-buffered, so the next digest can be captured while the current one is still draining.

---
 rtl/sm3_digest_tx.sv | 130 +++++++++++++
 1 files changed

// File: rtl/sm3_digest_tx.sv
// sm3_digest_tx: double-buffered SM3 digest serializer over a valid/ready byte
// stream. It emits digests MSB-first, either as 32 raw bytes or as 64 lowercase
// ASCII hex characters.
module sm3_digest_tx #(
    parameter int unsigned HEX_MODE = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         digest_valid,
    input  logic [0:255] digest,
    output logic [0:7]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         tx_last,
    output logic         busy,
    output logic         overflow
);

    localparam int unsigned CNT_W = 6;
    localparam logic [CNT_W-1:0] TERM = (HEX_MODE != 0) ? CNT_W'(63) : CNT_W'(31);

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state, state_n;
    logic [0:255]     act_q, act_n;
    logic [0:255]     pend_q, pend_n;
    logic             pend_full, pend_full_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             ovf_n;
    logic             xfer, last_xfer;
    logic [0:7]       data_n;
    logic             last_n;
    logic [4:0]       byte_idx;
    logic [0:7]       byte_sel;
    logic [3:0]       nib;
    logic [7:0]       ascii;

    // State register; SEND means the active buffer holds a digest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Buffers, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q     <= '0;
            pend_q    <= '0;
            pend_full <= 1'b0;
            cnt_q     <= '0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            tx_last   <= 1'b0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            act_q     <= act_n;
            pend_q    <= pend_n;
            pend_full <= pend_full_n;
            cnt_q     <= cnt_n;
            tx_data   <= data_n;
            tx_valid  <= (state_n == SEND);
            tx_last   <= last_n;
            busy      <= (state_n == SEND) | pend_full_n;
            overflow  <= ovf_n;
        end
    end

    // Next state: apply this cycle's transfer first, then place any new digest.
    always_comb begin
        state_n     = state;
        act_n       = act_q;
        pend_n      = pend_q;
        pend_full_n = pend_full;
        cnt_n       = cnt_q;
        ovf_n       = overflow;
        xfer        = tx_valid && tx_ready;
        last_xfer   = xfer && (cnt_q == TERM);
        case (state)
            IDLE: begin
                if (digest_valid) begin
                    state_n = SEND;
                    act_n   = digest;
                    cnt_n   = '0;
                end
            end
            SEND: begin
                if (last_xfer) begin
                    cnt_n = '0;
                    if (pend_full) begin
                        act_n       = pend_q;
                        pend_full_n = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (xfer) begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
                if (digest_valid) begin
                    if (state_n == IDLE) begin
                        state_n = SEND;
                        act_n   = digest;
                        cnt_n   = '0;
                    end else if (!pend_full_n) begin
                        pend_n      = digest;
                        pend_full_n = 1'b1;
                    end else begin
                        ovf_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Output: select the character the next cycle will present.
    always_comb begin
        byte_idx = (HEX_MODE != 0) ? cnt_n[5:1] : cnt_n[4:0];
        byte_sel = act_n[{byte_idx, 3'b000} +: 8];
        nib      = cnt_n[0] ? byte_sel[4:7] : byte_sel[0:3];
        ascii    = (nib < 4'd10) ? (8'h30 + 8'(nib)) : (8'h57 + 8'(nib));
        data_n   = '0;
        last_n   = 1'b0;
        if (state_n == SEND) begin
            data_n = (HEX_MODE != 0) ? ascii : byte_sel;
            last_n = (cnt_n == TERM);
        end
    end

endmodule
